// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_arb16 single-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_H    = 2'd3
    } owner_e;

    localparam logic [1:0] WE_READ        = 2'b00;
    localparam int         STARVE_MAX_DEF = 3;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied instruction-request cycles; starve
// is high once the count reaches STARVE_MAX.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    input  logic hold,
    output logic starve
);

    localparam int              CW      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    // Frozen entirely while the host owns the memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!hold) begin
            if (!req || gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

    assign starve = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/mem_arb16.sv
// Single-port SRAM arbiter: host > data > instruction, with instruction starvation
// override. Host port compiled in only when MEM_ARB_HOST_PORT_EN is defined.
module mem_arb16
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int MW         = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [15:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [15:0]   i_rdata,
    input  logic          d_req,
    input  logic [1:0]    d_we,
    input  logic [15:0]   d_addr,
    input  logic [15:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [15:0]   d_rdata,
    input  logic          h_req,
    input  logic [1:0]    h_we,
    input  logic [15:0]   h_addr,
    input  logic [15:0]   h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [15:0]   h_rdata,
    output logic          m_en,
    output logic [1:0]    m_we,
    output logic [MW-1:0] m_addr,
    output logic [15:0]   m_wdata,
    input  logic [15:0]   m_rdata
);

    logic          h_win;
    logic          d_win;
    logic          i_win;
    logic          starve;
    logic [15:0]   sel_addr;
    owner_e        gnt_owner;
    owner_e        rd_next;
    owner_e        rd_owner;
    logic [15:0]   i_rdata_p1;
    logic [15:0]   d_rdata_p1;
    logic          unused_addr_bits;

`ifdef MEM_ARB_HOST_PORT_EN
    assign h_win = h_req && !rst;
`else
    assign h_win = 1'b0;
`endif

    // Stage p0: combinational grant and memory strobe.
    assign d_win = d_req && !rst && !h_win && !(i_req && starve);
    assign i_win = i_req && !rst && !h_win && !d_win;

    assign h_gnt = h_win;
    assign d_gnt = d_win;
    assign i_gnt = i_win;

    always_comb begin
        sel_addr  = '0;
        m_we      = WE_READ;
        m_wdata   = '0;
        gnt_owner = OWN_NONE;
        if (h_win) begin
            sel_addr  = h_addr;
            m_we      = h_we;
            m_wdata   = h_wdata;
            gnt_owner = OWN_H;
        end else if (d_win) begin
            sel_addr  = d_addr;
            m_we      = d_we;
            m_wdata   = d_wdata;
            gnt_owner = OWN_D;
        end else if (i_win) begin
            sel_addr  = i_addr;
            gnt_owner = OWN_I;
        end
    end

    assign m_en    = h_win || d_win || i_win;
    assign m_addr  = sel_addr[MW:1];
    assign rd_next = (m_en && (m_we == WE_READ)) ? gnt_owner : OWN_NONE;

    // Byte-select bit and any bits above the word address never reach memory.
    assign unused_addr_bits = ^sel_addr;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .req    (i_req),
        .gnt    (i_win),
        .hold   (h_win),
        .starve (starve)
    );

    // Stage p1: read return, one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= rd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata_p1 <= '0;
            d_rdata_p1 <= '0;
        end else begin
            if (rd_owner == OWN_I) i_rdata_p1 <= m_rdata;
            if (rd_owner == OWN_D) d_rdata_p1 <= m_rdata;
        end
    end

    assign i_rvalid = (rd_owner == OWN_I);
    assign d_rvalid = (rd_owner == OWN_D);
    assign i_rdata  = i_rvalid ? m_rdata : i_rdata_p1;
    assign d_rdata  = d_rvalid ? m_rdata : d_rdata_p1;

`ifdef MEM_ARB_HOST_PORT_EN
    logic [15:0] h_rdata_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_rdata_p1 <= '0;
        end else if (rd_owner == OWN_H) begin
            h_rdata_p1 <= m_rdata;
        end
    end

    assign h_rvalid = (rd_owner == OWN_H);
    assign h_rdata  = h_rvalid ? m_rdata : h_rdata_p1;
`else
    assign h_rvalid = 1'b0;
    assign h_rdata  = 16'h0;
`endif

endmodule

// File: tb/tb_mem_arb16.sv
// Self-checking bench for mem_arb16: SRAM model, reference memory and a read-return scoreboard.
module tb_mem_arb16;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [15:0]   i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [15:0]   i_rdata;
    logic          d_req;
    logic [1:0]    d_we;
    logic [15:0]   d_addr;
    logic [15:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [15:0]   d_rdata;
    logic          h_req;
    logic [1:0]    h_we;
    logic [15:0]   h_addr;
    logic [15:0]   h_wdata;
    logic          h_gnt;
    logic          h_rvalid;
    logic [15:0]   h_rdata;
    logic          m_en;
    logic [1:0]    m_we;
    logic [14:0]   m_addr;
    logic [15:0]   m_wdata;
    logic [15:0]   m_rdata;

    mem_arb16 #(.STARVE_MAX(3), .MW(15)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    localparam logic [2:0] G_NONE = 3'b000;
    localparam logic [2:0] G_I    = 3'b001;
    localparam logic [2:0] G_D    = 3'b010;
    localparam logic [2:0] G_H    = 3'b100;

    typedef struct {
        int          own;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic        mon_en = 1'b0;
    logic [2:0]  t5 [0:4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read, byte-writable SRAM.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we == 2'b00) m_rdata <= mem[m_addr];
            if (m_we[0]) mem[m_addr][7:0]  <= m_wdata[7:0];
            if (m_we[1]) mem[m_addr][15:8] <= m_wdata[15:8];
        end
    end

    function automatic logic [15:0] pat(input int w);
        return {w[7:0] ^ 8'hA5, w[7:0] + 8'h11};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Read-return monitor: exactly the scoreboard's due entry may raise rvalid.
    always @(negedge clk) begin
        exp_t       e;
        logic [2:0] ev;
        if (mon_en) begin
            ev = 3'b000;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                ev[e.own-1] = 1'b1;
                case (e.own)
                    1:       chk("i_rdata", i_rdata, e.data);
                    2:       chk("d_rdata", d_rdata, e.data);
                    default: chk("h_rdata", h_rdata, e.data);
                endcase
            end
            chk("rvalid", {h_rvalid, d_rvalid, i_rvalid}, ev);
        end
    end

    // Called just after a rising edge with inputs set; checks this cycle's grant.
    task automatic step(input string tag, input logic [2:0] eg);
        logic [15:0] a;
        logic [1:0]  we;
        logic [15:0] wd;
        int          own;
        a = '0; we = 2'b00; wd = '0; own = 0;
        if (eg[2])      begin a = h_addr; we = h_we; wd = h_wdata; own = 3; end
        else if (eg[1]) begin a = d_addr; we = d_we; wd = d_wdata; own = 2; end
        else if (eg[0]) begin a = i_addr; own = 1; end
        if (eg != G_NONE) begin
            if (we == 2'b00) begin
                sb_q.push_back('{own, ref_mem[a[15:1]], cyc + 1});
            end else begin
                if (we[0]) ref_mem[a[15:1]][7:0]  = wd[7:0];
                if (we[1]) ref_mem[a[15:1]][15:8] = wd[15:8];
            end
        end
        @(negedge clk);
        chk({tag, "_gnt"}, {h_gnt, d_gnt, i_gnt}, eg);
        chk({tag, "_m_en"}, m_en, (eg != G_NONE));
        chk({tag, "_m_we"}, m_we, we);
        if (eg != G_NONE) chk({tag, "_m_addr"}, m_addr, a[15:1]);
        if (we != 2'b00)  chk({tag, "_m_wdata"}, m_wdata, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req = 1'b0; d_req = 1'b0; h_req = 1'b0;
        d_we = 2'b00; h_we = 2'b00;
        step("idle", G_NONE);
    endtask

    initial begin
        int dcnt;
        for (int w = 0; w < 32768; w++) begin
            mem[w]     = pat(w);
            ref_mem[w] = pat(w);
        end
`ifdef MEM_ARB_HOST_PORT_EN
        t5[0] = G_D; t5[1] = G_D; t5[2] = G_H; t5[3] = G_D; t5[4] = G_I;
`else
        t5[0] = G_D; t5[1] = G_D; t5[2] = G_D; t5[3] = G_I; t5[4] = G_D;
`endif
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 2'b00; d_addr = '0; d_wdata = '0;
        h_req = 1'b0; h_we = 2'b00; h_addr = '0; h_wdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Requests under reset are never granted.
        i_req = 1'b1; d_req = 1'b1; d_addr = 16'h0010;
        step("rst_req", G_NONE);
        mon_en = 1'b1;
        rst = 1'b0;
        idle();
        chk("rst_i_rdata", i_rdata, 16'h0);
        chk("rst_d_rdata", d_rdata, 16'h0);
        chk("rst_h_rdata", h_rdata, 16'h0);

        // Instruction fetch of byte address 4 -> word 2.
        i_req = 1'b1; i_addr = 16'h0004;
        step("ifetch", G_I);
        idle();
        chk("ifetch_data", i_rdata, 16'hA713);

        // Low-byte write then read-back of the same word.
        d_req = 1'b1; d_we = 2'b01; d_addr = 16'h0010; d_wdata = 16'hABCD;
        step("dwr", G_D);
        d_we = 2'b00;
        step("drd", G_D);
        idle();
        chk("wr_rd_data", d_rdata, 16'hADCD);

        // Continuous contention: three data grants, then the instruction.
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            i_req = 1'b1; i_addr = (k < 4) ? 16'h0050 : 16'h0052;
            d_req = 1'b1; d_we = 2'b00; d_addr = 16'h0040 + 16'(2 * dcnt);
            if (k == 3 || k == 7) begin
                step("starve", G_I);
            end else begin
                step("starve", G_D);
                dcnt++;
            end
        end
        idle();

        // Host request in the middle of contention.
        for (int k = 0; k < 5; k++) begin
            i_req = 1'b1; i_addr = 16'h0030;
            d_req = 1'b1; d_we = 2'b00; d_addr = 16'h0020;
            h_req = (k == 2); h_we = 2'b00; h_addr = 16'h0100;
            step("host", t5[k]);
        end
        h_req = 1'b0;
        idle();

        // Read requested in the reset cycle is dropped.
        rst = 1'b1; d_req = 1'b1; d_we = 2'b00; d_addr = 16'h0010;
        step("rst_rd", G_NONE);
        rst = 1'b0;
        chk("rst_rd_d_rdata", d_rdata, 16'h0);
        idle();

        // Top byte address maps to the top word.
        i_req = 1'b1; i_addr = 16'hFFFF;
        step("top", G_I);
        idle();
        chk("top_data", i_rdata, 16'h5A10);

        idle();
        idle();
        chk("sb_empty", sb_q.size(), 0);
`ifdef MEM_ARB_HOST_PORT_EN
        chk("h_rdata_end", h_rdata, 16'h2591);
`else
        chk("h_rdata_end", h_rdata, 16'h0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
